// File: rtl/adder_acc_pkg.sv
// Shared types and default widths for the adder accumulator stage.
package adder_acc_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ACC_W  = 24;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_accumulator_if.sv
// Control, sample-in and result-out handshakes of the adder accumulator.
interface adder_accumulator_if
  import adder_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
);

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_c_out;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;
  logic              busy;

  modport master (
    output start, len, in_valid, in_sum, in_c_out, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_sum, in_c_out, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );

endinterface

// File: rtl/adder_acc_core.sv
// ACC_W-wide add with carry-out; clamps to all-ones on carry when
// ADDER_ACC_SATURATE_EN is defined, otherwise wraps.
module adder_acc_core
  import adder_acc_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] sample,
  output logic [ACC_W-1:0] next_c,
  output logic             carry_c
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw     = {1'b0, acc} + {1'b0, sample};
    carry_c = raw[ACC_W];
`ifdef ADDER_ACC_SATURATE_EN
    // Once clamped, any further non-zero sample carries again, so the clamp holds.
    next_c  = carry_c ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    next_c  = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/adder_accumulator.sv
// Sequential reduction stage: sums len {c_out,sum} samples and presents the total
// with a sticky overflow flag. Optional macro: ADDER_ACC_SATURATE_EN.
module adder_accumulator
  import adder_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst,
  adder_accumulator_if.slave bus
);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  len_q;
  logic [ACC_W-1:0]  acc;
  logic              ovf_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [DATA_W:0]   operand_c;
  logic [ACC_W-1:0]  sample_c;
  logic [ACC_W-1:0]  acc_next_c;
  logic              carry_c;
  logic              xfer_c;

  assign operand_c = {bus.in_c_out, bus.in_sum};
  assign sample_c  = ACC_W'(operand_c);
  assign xfer_c    = bus.in_valid & in_ready_q;

  adder_acc_core #(.ACC_W(ACC_W)) u_core (
    .acc     (acc),
    .sample  (sample_c),
    .next_c  (acc_next_c),
    .carry_c (carry_c)
  );

  // FSM with counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      len_q       <= '0;
      acc         <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q  <= bus.len;
            acc    <= '0;
            ovf_q  <= 1'b0;
            count  <= '0;
            busy_q <= 1'b1;
            if (bus.len == '0) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state      <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (xfer_c) begin
            acc   <= acc_next_c;
            ovf_q <= ovf_q | carry_c;
            count <= count + CNT_W'(1);
            if (count == len_q - CNT_W'(1)) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here, even alongside out_ready
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench for adder_accumulator: transaction-level model plus directed vectors.
module tb_adder_accumulator;
  import adder_acc_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 8;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  adder_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  adder_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 collecting samples, 2 presenting the result
  int     m_phase = 0;
  int     m_len   = 0;
  int     m_cnt   = 0;
  longint m_sum   = 0;
  bit     m_after_rst = 1'b0;

  function automatic logic [ACC_W-1:0] exp_acc(input longint s);
`ifdef ADDER_ACC_SATURATE_EN
    return (s > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(s);
`else
    return ACC_W'(s);
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_sum = 0; m_cnt = 0; m_after_rst = 1'b1;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_len = int'(bus.len); m_sum = 0; m_cnt = 0; m_after_rst = 1'b0;
          m_phase = (m_len == 0) ? 2 : 1;
        end
        1: if (bus.in_valid) begin
          m_sum += longint'({bus.in_c_out, bus.in_sum});
          m_cnt++;
          if (m_cnt == m_len) m_phase = 2;
        end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready),  32'(m_phase == 1));
    chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
    chk("busy",      32'(bus.busy),      32'(m_phase != 0));
    if (m_phase == 2 || m_after_rst) begin
      chk("out_acc", 32'(bus.out_acc), 32'(exp_acc(m_sum)));
      chk("out_ovf", 32'(bus.out_ovf), 32'(m_sum > ACC_MAX));
    end
  end

  task automatic do_start(input int l);
    bus.start = 1'b1;
    bus.len   = CNT_W'(l);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [15:0] s, input logic c);
    logic got;
    int   n;
    bus.in_valid = 1'b1; bus.in_sum = s; bus.in_c_out = c;
    n = 0;
    do begin
      got = bus.in_ready;
      @(negedge clk);
      n++;
    end while (!got && n < 50);
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready never seen, sample %0h", s);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  logic [15:0] t4_sum [5] = '{16'h1234, 16'h5555, 16'h0100, 16'h6666, 16'h7777};
  logic        t4_c   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        t4_v   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [ACC_W-1:0] held;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_sum = '0; bus.in_c_out = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_acc",   32'(bus.out_acc),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: four small samples
    do_start(4);
    send(16'h0000, 1'b0); send(16'h0001, 1'b0); send(16'h000B, 1'b0); send(16'h0012, 1'b0);
    chk("t1_latency", 32'(bus.out_valid), 32'd1);
    chk("t1_acc",     32'(bus.out_acc),   32'h00001E);
    chk("t1_ovf",     32'(bus.out_ovf),   32'd0);
    take_out();

    // 2: overflow run
    do_start(129);
    for (int i = 0; i < 129; i++) send(16'hFFFF, 1'b1);
`ifdef ADDER_ACC_SATURATE_EN
    chk("t2_acc", 32'(bus.out_acc), 32'hFFFFFF);
`else
    chk("t2_acc", 32'(bus.out_acc), 32'h01FF7F);
`endif
    chk("t2_ovf", 32'(bus.out_ovf), 32'd1);
    take_out();

    // 3: len 0 with a sample offered that must not be consumed
    bus.in_valid = 1'b1; bus.in_sum = 16'hABCD; bus.in_c_out = 1'b1;
    do_start(0);
    chk("t3_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_acc",   32'(bus.out_acc),   32'd0);
    chk("t3_ovf",   32'(bus.out_ovf),   32'd0);
    take_out();
    bus.in_valid = 1'b0;

    // 4: gapped in_valid, then back-pressure on the result
    do_start(2);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = t4_v[i]; bus.in_sum = t4_sum[i]; bus.in_c_out = t4_c[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("t4_acc", 32'(bus.out_acc), 32'h011334);
    held = bus.out_acc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_acc",   32'(bus.out_acc),   32'(held));
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    take_out();
    chk("t4_idle", 32'(bus.out_valid), 32'd0);

    // 5: reset mid-run
    do_start(3);
    send(16'h4000, 1'b1); send(16'h0001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_busy",     32'(bus.busy),     32'd0);
    chk("t5_acc",      32'(bus.out_acc),  32'd0);
    chk("t5_ovf",      32'(bus.out_ovf),  32'd0);
    do_start(1);
    send(16'h00FF, 1'b1);
    chk("t5_rerun_acc", 32'(bus.out_acc), 32'h0100FF);
    take_out();

    // 6: start ignored in ACCUM and in DONE
    do_start(3);
    send(16'h0005, 1'b0);
    bus.start = 1'b1; bus.len = CNT_W'(7);
    @(negedge clk);
    bus.start = 1'b0;
    send(16'h0006, 1'b0); send(16'h0007, 1'b1);
    chk("t6_done", 32'(bus.out_valid), 32'd1);
    chk("t6_acc",  32'(bus.out_acc),   32'h010012);
    bus.start = 1'b1; bus.len = CNT_W'(5); bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.out_ready = 1'b0;
    chk("t6_no_restart_busy",  32'(bus.busy),      32'd0);
    chk("t6_no_restart_valid", 32'(bus.out_valid), 32'd0);
    do_start(1);
    send(16'h00AB, 1'b0);
    chk("t6_next_acc", 32'(bus.out_acc), 32'h0000AB);
    take_out();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
